// File: rtl/multitap_keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : multitap_keypad_encoder
// Description : Scans an R x C matrix keypad, debounces presses/releases and
//               turns repeated taps of one key into a cycling phone-style
//               letter. Emits committed ASCII letters plus word-submit, clear
//               and key-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module multitap_keypad_encoder #(
   parameter int NUM_ROWS        = 4,
   parameter int NUM_COLS        = 4,
   parameter int SCAN_CYCLES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TAP_TIMEOUT     = 50,
   parameter int TIMEOUT_COMMIT  = 1,
   parameter int SUBMIT_KEY      = 8,
   parameter int CLEAR_KEY       = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_COLS-1:0] col,
   output logic                pending,
   output logic [7:0]          pending_char,
   output logic [7:0]          letter,
   output logic                letter_valid,
   output logic                word_submit,
   output logic                clear,
   output logic                key_error
);

   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
   localparam int KEY_W    = $clog2(NUM_KEYS);
   localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int SCAN_W   = $clog2(SCAN_CYCLES + 1);
   localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W     = $clog2(TAP_TIMEOUT + 1);

   localparam logic [1:0] S_SCAN        = 2'd0;
   localparam logic [1:0] S_DEB_PRESS   = 2'd1;
   localparam logic [1:0] S_HELD        = 2'd2;
   localparam logic [1:0] S_DEB_RELEASE = 2'd3;

   localparam logic [0:0] T_IDLE    = 1'b0;
   localparam logic [0:0] T_PENDING = 1'b1;

   // First letter of each tap group (ABC, DEF, ... WXYZ)
   function automatic logic [7:0] group_base(input logic [2:0] g);
      logic [7:0] b;
      b = 8'h41;
      case (g)
         3'd0: b = 8'h41;
         3'd1: b = 8'h44;
         3'd2: b = 8'h47;
         3'd3: b = 8'h4A;
         3'd4: b = 8'h4D;
         3'd5: b = 8'h50;
         3'd6: b = 8'h54;
         3'd7: b = 8'h57;
         default: b = 8'h41;
      endcase
      return b;
   endfunction

   // Highest tap index before wrapping: PQRS and WXYZ have four letters
   function automatic logic [1:0] group_last(input logic [2:0] g);
      return ((g == 3'd5) || (g == 3'd7)) ? 2'd3 : 2'd2;
   endfunction

   logic [1:0]          scan_state_q, scan_state_d;
   logic [COL_W-1:0]    col_idx_q, col_idx_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [NUM_ROWS-1:0] row_lat_q, row_lat_d;
   logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
   logic [0:0]          tap_state_q, tap_state_d;
   logic [2:0]          pend_key_q, pend_key_d;
   logic [1:0]          tap_cnt_q, tap_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [7:0]          letter_q, letter_d;
   logic                letter_valid_q, letter_valid_d;
   logic                word_submit_q, word_submit_d;
   logic                clear_q, clear_d;
   logic                key_error_q, key_error_d;

   logic                accept;
   logic [ROW_W-1:0]    row_idx;
   logic [KEY_W-1:0]    acc_key;
   logic                is_letter, is_submit, is_clear;
   logic [7:0]          cur_char;

   // State register for both the scan and the tap machines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_state_q   <= S_SCAN;
         col_idx_q      <= '0;
         scan_cnt_q     <= '0;
         row_lat_q      <= '0;
         deb_cnt_q      <= '0;
         tap_state_q    <= T_IDLE;
         pend_key_q     <= '0;
         tap_cnt_q      <= '0;
         to_cnt_q       <= '0;
         letter_q       <= '0;
         letter_valid_q <= 1'b0;
         word_submit_q  <= 1'b0;
         clear_q        <= 1'b0;
         key_error_q    <= 1'b0;
      end else begin
         scan_state_q   <= scan_state_d;
         col_idx_q      <= col_idx_d;
         scan_cnt_q     <= scan_cnt_d;
         row_lat_q      <= row_lat_d;
         deb_cnt_q      <= deb_cnt_d;
         tap_state_q    <= tap_state_d;
         pend_key_q     <= pend_key_d;
         tap_cnt_q      <= tap_cnt_d;
         to_cnt_q       <= to_cnt_d;
         letter_q       <= letter_d;
         letter_valid_q <= letter_valid_d;
         word_submit_q  <= word_submit_d;
         clear_q        <= clear_d;
         key_error_q    <= key_error_d;
      end
   end

   // Decode the latched row pattern (lowest row wins) into a key index
   always_comb begin
      row_idx = '0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (row_lat_q[i]) row_idx = ROW_W'(i);
      end
      acc_key   = KEY_W'(int'(row_idx) * NUM_COLS + int'(col_idx_q));
      is_letter = (acc_key < KEY_W'(8));
      is_submit = (acc_key == KEY_W'(SUBMIT_KEY));
      is_clear  = (acc_key == KEY_W'(CLEAR_KEY));
      cur_char  = group_base(pend_key_q) + {6'd0, tap_cnt_q};
   end

   // Scan/debounce next state; accept fires once per debounced press
   always_comb begin
      scan_state_d = scan_state_q;
      col_idx_d    = col_idx_q;
      scan_cnt_d   = scan_cnt_q;
      row_lat_d    = row_lat_q;
      deb_cnt_d    = deb_cnt_q;
      accept       = 1'b0;
      case (scan_state_q)
         S_SCAN: begin
            if (row != '0) begin
               // Column freezes so the latched key index stays valid
               row_lat_d    = row;
               scan_cnt_d   = '0;
               deb_cnt_d    = '0;
               scan_state_d = S_DEB_PRESS;
            end else if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
               scan_cnt_d = '0;
               col_idx_d  = (col_idx_q == COL_W'(NUM_COLS - 1)) ? '0 : col_idx_q + 1'b1;
            end else begin
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end
         S_DEB_PRESS: begin
            if (row == row_lat_q) begin
               if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                  accept       = 1'b1;
                  deb_cnt_d    = '0;
                  scan_state_d = S_HELD;
               end else begin
                  deb_cnt_d = deb_cnt_q + 1'b1;
               end
            end else begin
               deb_cnt_d    = '0;
               scan_state_d = S_SCAN;
            end
         end
         S_HELD: begin
            if (row == '0) begin
               deb_cnt_d    = '0;
               scan_state_d = S_DEB_RELEASE;
            end
         end
         S_DEB_RELEASE: begin
            if (row == '0) begin
               if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                  deb_cnt_d    = '0;
                  scan_state_d = S_SCAN;
               end else begin
                  deb_cnt_d = deb_cnt_q + 1'b1;
               end
            end else begin
               deb_cnt_d    = '0;
               scan_state_d = S_HELD;
            end
         end
         default: scan_state_d = S_SCAN;
      endcase
   end

   // Tap machine next state: accepts take priority over the timeout
   always_comb begin
      tap_state_d    = tap_state_q;
      pend_key_d     = pend_key_q;
      tap_cnt_d      = tap_cnt_q;
      to_cnt_d       = to_cnt_q;
      letter_d       = letter_q;
      letter_valid_d = 1'b0;
      word_submit_d  = 1'b0;
      clear_d        = 1'b0;
      key_error_d    = 1'b0;
      if (accept) begin
         if (is_letter) begin
            if ((tap_state_q == T_PENDING) && (acc_key[2:0] == pend_key_q)) begin
               tap_cnt_d = (tap_cnt_q == group_last(pend_key_q)) ? 2'd0 : tap_cnt_q + 2'd1;
               to_cnt_d  = '0;
            end else begin
               // A different letter key commits the old letter first
               if (tap_state_q == T_PENDING) begin
                  letter_d       = cur_char;
                  letter_valid_d = 1'b1;
               end
               tap_state_d = T_PENDING;
               pend_key_d  = acc_key[2:0];
               tap_cnt_d   = 2'd0;
               to_cnt_d    = '0;
            end
         end else if (is_submit) begin
            if (tap_state_q == T_PENDING) begin
               letter_d       = cur_char;
               letter_valid_d = 1'b1;
               tap_state_d    = T_IDLE;
               tap_cnt_d      = 2'd0;
               to_cnt_d       = '0;
            end else begin
               word_submit_d = 1'b1;
            end
         end else if (is_clear) begin
            clear_d     = 1'b1;
            tap_state_d = T_IDLE;
            tap_cnt_d   = 2'd0;
            to_cnt_d    = '0;
         end else begin
            key_error_d = 1'b1;
         end
      end else if (tap_state_q == T_PENDING) begin
         if (to_cnt_q == TO_W'(TAP_TIMEOUT - 1)) begin
            if (TIMEOUT_COMMIT != 0) begin
               letter_d       = cur_char;
               letter_valid_d = 1'b1;
            end
            tap_state_d = T_IDLE;
            tap_cnt_d   = 2'd0;
            to_cnt_d    = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Outputs come straight from registered state
   always_comb begin
      col          = NUM_COLS'(1) << col_idx_q;
      pending      = (tap_state_q == T_PENDING);
      pending_char = pending ? cur_char : 8'h00;
      letter       = letter_q;
      letter_valid = letter_valid_q;
      word_submit  = word_submit_q;
      clear        = clear_q;
      key_error    = key_error_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_multitap_keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multitap_keypad_encoder
// Description : Self-checking bench for multitap_keypad_encoder with a
//               behavioural keypad matrix and an event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multitap_keypad_encoder;

   localparam int NR = 4;
   localparam int NC = 4;

   localparam logic [2:0] EV_NONE   = 3'd0;
   localparam logic [2:0] EV_LETTER = 3'd1;
   localparam logic [2:0] EV_SUBMIT = 3'd2;
   localparam logic [2:0] EV_CLEAR  = 3'd3;
   localparam logic [2:0] EV_ERROR  = 3'd4;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] ch;
   } evt_t;

   typedef struct {
      int         key;
      logic       exp_pend;
      logic [7:0] exp_char;
      logic [2:0] ev_kind;
      logic [7:0] ev_ch;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] row;
   logic [NC-1:0] col, col_nc;
   logic          pending, pending_nc;
   logic [7:0]    pending_char, pending_char_nc, letter, letter_nc;
   logic          letter_valid, word_submit, clear, key_error;
   logic          letter_valid_nc, word_submit_nc, clear_nc, key_error_nc;

   int            pressed_key = -1;
   logic [NR-1:0] glitch_row  = '0;
   int            checks = 0;
   int            errors = 0;
   int            nc_lv_cnt = 0;
   evt_t          exp_q[$];
   vec_t          vecs[$];

   always #5 clk = ~clk;

   multitap_keypad_encoder #(.TIMEOUT_COMMIT(1)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .pending(pending), .pending_char(pending_char), .letter(letter),
      .letter_valid(letter_valid), .word_submit(word_submit),
      .clear(clear), .key_error(key_error)
   );

   multitap_keypad_encoder #(.TIMEOUT_COMMIT(0)) dut_nc (
      .clk(clk), .rst(rst), .row(row), .col(col_nc),
      .pending(pending_nc), .pending_char(pending_char_nc), .letter(letter_nc),
      .letter_valid(letter_valid_nc), .word_submit(word_submit_nc),
      .clear(clear_nc), .key_error(key_error_nc)
   );

   // Keypad matrix: a held key shorts its column strobe onto its row line
   always_comb begin
      row = glitch_row;
      if (pressed_key >= 0 && col[pressed_key % NC]) row[pressed_key / NC] = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check_evt(input logic [2:0] kind, input logic [7:0] ch);
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event_unexpected: got kind %0d char %h, required none", kind, ch);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.ch != ch) begin
            errors++;
            $display("FAIL event_order: got kind %0d char %h, required kind %0d char %h",
                     kind, ch, e.kind, e.ch);
         end
      end
   endtask

   // Scoreboard monitor on the committing instance
   always @(negedge clk) begin
      if (letter_valid) check_evt(EV_LETTER, letter);
      if (word_submit)  check_evt(EV_SUBMIT, 8'h00);
      if (clear)        check_evt(EV_CLEAR, 8'h00);
      if (key_error)    check_evt(EV_ERROR, 8'h00);
      if (letter_valid_nc) nc_lv_cnt++;
   end

   task automatic push_evt(input logic [2:0] kind, input logic [7:0] ch);
      evt_t e;
      e.kind = kind;
      e.ch   = ch;
      exp_q.push_back(e);
   endtask

   task automatic tap(input int k);
      @(negedge clk);
      pressed_key = k;
      repeat (16) @(negedge clk);
      pressed_key = -1;
      repeat (8) @(negedge clk);
   endtask

   task automatic add_vec(input int k, input logic p, input logic [7:0] c,
                          input logic [2:0] kind, input logic [7:0] ch);
      vec_t v;
      v.key = k; v.exp_pend = p; v.exp_char = c; v.ev_kind = kind; v.ev_ch = ch;
      vecs.push_back(v);
   endtask

   initial begin
      // Tap table: key, pending, pending_char, expected event
      add_vec(0,  1'b1, 8'h41, EV_NONE,   8'h00);
      add_vec(8,  1'b0, 8'h00, EV_LETTER, 8'h41);
      add_vec(5,  1'b1, 8'h50, EV_NONE,   8'h00);
      add_vec(5,  1'b1, 8'h51, EV_NONE,   8'h00);
      add_vec(5,  1'b1, 8'h52, EV_NONE,   8'h00);
      add_vec(5,  1'b1, 8'h53, EV_NONE,   8'h00);
      add_vec(5,  1'b1, 8'h50, EV_NONE,   8'h00);
      add_vec(8,  1'b0, 8'h00, EV_LETTER, 8'h50);
      add_vec(3,  1'b1, 8'h4A, EV_NONE,   8'h00);
      add_vec(3,  1'b1, 8'h4B, EV_NONE,   8'h00);
      add_vec(2,  1'b1, 8'h47, EV_LETTER, 8'h4B);
      add_vec(8,  1'b0, 8'h00, EV_LETTER, 8'h47);
      add_vec(8,  1'b0, 8'h00, EV_SUBMIT, 8'h00);
      add_vec(0,  1'b1, 8'h41, EV_NONE,   8'h00);
      add_vec(0,  1'b1, 8'h42, EV_NONE,   8'h00);
      add_vec(9,  1'b0, 8'h00, EV_CLEAR,  8'h00);
      add_vec(10, 1'b0, 8'h00, EV_ERROR,  8'h00);
      add_vec(7,  1'b1, 8'h57, EV_NONE,   8'h00);
      add_vec(7,  1'b1, 8'h58, EV_NONE,   8'h00);
      add_vec(7,  1'b1, 8'h59, EV_NONE,   8'h00);
      add_vec(7,  1'b1, 8'h5A, EV_NONE,   8'h00);
      add_vec(7,  1'b1, 8'h57, EV_NONE,   8'h00);
      add_vec(6,  1'b1, 8'h54, EV_LETTER, 8'h57);
      add_vec(10, 1'b1, 8'h54, EV_ERROR,  8'h00);

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_col", 32'(col), 32'h1);
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_pending_char", 32'(pending_char), 32'h0);
      chk("reset_letter", 32'(letter), 32'h0);
      chk("reset_pulses", 32'({letter_valid, word_submit, clear, key_error}), 32'h0);
      rst = 1'b0;

      // Idle column rotation, two clocks per column
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         chk("scan_col", 32'(col), 32'(1 << ((n / 2) % NC)));
      end

      // Table-driven taps with a glitch check before the second phase
      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 8) begin
            @(negedge clk);
            glitch_row = 4'b0001;
            repeat (2) @(negedge clk);
            glitch_row = '0;
            repeat (16) @(negedge clk);
            chk("glitch_pending", 32'(pending), 32'h0);
         end
         if (vecs[i].ev_kind != EV_NONE) push_evt(vecs[i].ev_kind, vecs[i].ev_ch);
         tap(vecs[i].key);
         chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
         chk($sformatf("vec%0d_pending_char", i), 32'(pending_char), 32'(vecs[i].exp_char));
         chk($sformatf("vec%0d_nc_pending", i), 32'(pending_nc), 32'(vecs[i].exp_pend));
      end

      // 'T' is still pending after the unmapped key: let it time out
      nc_lv_cnt = 0;
      push_evt(EV_LETTER, 8'h54);
      repeat (60) @(negedge clk);
      chk("timeout_t_pending", 32'(pending), 32'h0);
      chk("timeout_t_letter", 32'(letter), 32'h54);
      chk("timeout_t_nc_pending", 32'(pending_nc), 32'h0);

      // Key 1 then idle: commit on one instance, silent discard on the other
      push_evt(EV_LETTER, 8'h44);
      tap(1);
      chk("timeout_d_before", 32'(pending_char), 32'h44);
      chk("timeout_d_nc_before", 32'(pending_char_nc), 32'h44);
      repeat (60) @(negedge clk);
      chk("timeout_d_pending", 32'(pending), 32'h0);
      chk("timeout_d_letter", 32'(letter), 32'h44);
      chk("timeout_nc_pending", 32'(pending_nc), 32'h0);
      chk("timeout_nc_char", 32'(pending_char_nc), 32'h0);
      chk("timeout_nc_no_pulse", 32'(nc_lv_cnt), 32'h0);

      // Asynchronous reset while a letter is pending
      tap(1);
      chk("pre_reset_pending", 32'(pending_char), 32'h44);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_pending", 32'(pending), 32'h0);
      chk("async_rst_char", 32'(pending_char), 32'h0);
      chk("async_rst_letter", 32'(letter), 32'h0);
      chk("async_rst_col", 32'(col), 32'h1);
      chk("async_rst_nc_pending", 32'(pending_nc), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_reset_pending", 32'(pending), 32'h0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multitap_keypad_encoder.md
Name: multitap_keypad_encoder

Overview:
Parametrised successor to the fixed 4-row keypad front end used on the host and player sides. It scans an R x C matrix keypad, debounces each press, and turns repeated taps of one key into a cycling letter (phone style: ABC, DEF, …, WXYZ). It emits committed ASCII letters, word-submit and clear pulses to the game/LCD logic, with a configurable tap timeout and timeout mode.

Parameters:
NUM_ROWS, 4, keypad rows sensed (≥1)
NUM_COLS, 4, keypad columns driven (≥1); NUM_ROWS*NUM_COLS ≥ 10
SCAN_CYCLES, 2, clocks each column stays strobed while scanning (≥1)
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a press or release (≥1)
TAP_TIMEOUT, 50, idle clocks after the last tap before the timeout action (≥1)
TIMEOUT_COMMIT, 1, 1 = timeout commits the pending letter; 0 = timeout discards it
SUBMIT_KEY, 8, key index of the submit key
CLEAR_KEY, 9, key index of the clear key

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
row  in  NUM_ROWS  row sense lines, active-high, synchronised externally
col  out  NUM_COLS  one-hot active-high column strobe
pending  out  1  a letter is being composed
pending_char  out  8  ASCII of the letter being composed; 8'h00 when not pending
letter  out  8  ASCII of the last committed letter; held until the next commit
letter_valid  out  1  one-cycle pulse when a letter is committed
word_submit  out  1  one-cycle pulse when submit is pressed with nothing pending
clear  out  1  one-cycle pulse when the clear key is accepted
key_error  out  1  one-cycle pulse when an unmapped key is accepted

Behaviour:
- Reset values: col = 1 (column 0), pending = 0, pending_char = 0, letter = 0, all pulse outputs = 0, all counters = 0, scan FSM in SCAN, tap FSM in IDLE.
- Key index = row_idx*NUM_COLS + col_idx. If several row bits are high, the lowest set row wins.
- Letter keys are indices 0–7 and map to groups ABC, DEF, GHI, JKL, MNO, PQRS, TUV, WXYZ. Group size is 4 for indices 5 and 7, 3 otherwise.
- SUBMIT_KEY and CLEAR_KEY must not fall in 0–7. Every other index is unmapped.
- Scan FSM states: SCAN, DEB_PRESS, HELD, DEB_RELEASE.
  - SCAN: col advances one position every SCAN_CYCLES clocks, wrapping from NUM_COLS-1 to 0. Any row bit high → latch the row pattern and move to DEB_PRESS; col freezes.
  - DEB_PRESS: the counter increments while row equals the latched pattern. On any mismatch, return to SCAN with col unchanged. When the counter reaches DEBOUNCE_CYCLES, the press is accepted (one-cycle internal event) and the FSM moves to HELD.
  - HELD: row == 0 → DEB_RELEASE.
  - DEB_RELEASE: needs DEBOUNCE_CYCLES consecutive row == 0 samples to return to SCAN. Any nonzero sample goes back to HELD. A held key never generates a second accept.
- Tap FSM states: IDLE, PENDING. It holds pend_key and tap_cnt (2 bits), plus a timeout counter.
- Accept handling, evaluated in the accept cycle; outputs are registered and appear the next cycle:
  - Letter key k in IDLE → PENDING, pend_key = k, tap_cnt = 0.
  - Letter key k in PENDING with k == pend_key → tap_cnt = (tap_cnt+1) mod group size; timeout counter cleared.
  - Letter key k in PENDING with k ≠ pend_key → commit the old letter (letter, letter_valid), then pend_key = k, tap_cnt = 0, all in the same cycle.
  - SUBMIT_KEY in PENDING → commit, go to IDLE. SUBMIT_KEY in IDLE → word_submit pulse.
  - CLEAR_KEY → clear pulse and IDLE with nothing committed, from either state.
  - Unmapped key → key_error pulse; tap state unchanged.
- Timeout: in PENDING, the counter increments each clock with no accept. On reaching TAP_TIMEOUT:
  - TIMEOUT_COMMIT = 1: commit and go to IDLE.
  - TIMEOUT_COMMIT = 0: discard and go to IDLE with no pulse.
  - An accept in the same cycle as the timeout takes priority; the timeout is ignored that cycle.
- pending_char = group base letter + tap_cnt while PENDING, otherwise 0.
- Reset asserted mid-operation returns to reset values immediately; a pending letter is lost and no pulse is emitted.

Test Plan:
- Reset, then idle for 20 clocks → col rotates 0001→0010→0100→1000→0001, changing every 2 clocks; no pulses.
- Key 0 (row0, col0) held 10 clocks, released; then key 8 (row2, col0) tapped → pending_char = 8'h41 after the press; on submit, letter = 8'h41 ('A') with a single letter_valid pulse.
- Key 5 tapped 5 times, then submit → P, Q, R, S, P; letter = 8'h50 ('P'), showing wrap-around at group size 4.
- Row0 glitch lasting 2 clocks → no accept. Key 3 tapped twice, then key 2 → letter_valid with 'K' (8'h4B), pending_char = 'G' (8'h47).
- Key 1 tapped, idle for 50 clocks → with TIMEOUT_COMMIT = 1, letter = 'D' (8'h44). Rerun with TIMEOUT_COMMIT = 0 → no pulse and pending = 0.
- Submit with nothing pending → word_submit pulse. Clear while pending 'B' → clear pulse, no letter_valid. Key 10 → key_error pulse. rst asserted while pending → all outputs return to 0 immediately.
